// File: rtl/instr_encoder_pkg.sv
// Shared MIPS encoding constants and the symbolic op set used by the
// instruction encoder and the pipeline control decoder.
package instr_encoder_pkg;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_LW      = 6'b100011;
  localparam logic [5:0] OPC_SW      = 6'b101011;
  localparam logic [5:0] OPC_LUI     = 6'b001111;
  localparam logic [5:0] OPC_BEQ     = 6'b000100;
  localparam logic [5:0] OPC_J       = 6'b000010;
  localparam logic [5:0] OPC_JAL     = 6'b000011;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_JR    = 6'b001000;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_ORI = 4'd3,
    OP_LW  = 4'd4,
    OP_SW  = 4'd5,
    OP_LUI = 4'd6,
    OP_BEQ = 4'd7,
    OP_J   = 4'd8,
    OP_JAL = 4'd9,
    OP_JR  = 4'd10
  } sym_op_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } im_word_t;

  localparam int unsigned IM_WORD_W = $bits(im_word_t);

  // Codes above the last defined op are reserved and rejected by the encoder.
  function automatic logic sym_op_valid(input logic [3:0] op);
    return op <= 4'(OP_JR);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of {addr, instr} entries with flush and active-low sync reset.
module instr_fifo
  import instr_encoder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 push_i,
  input  logic [IM_WORD_W-1:0] wdata_i,
  input  logic                 pop_i,
  output logic [IM_WORD_W-1:0] rdata_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [IM_WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (reset && !clear_i && do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder: symbolic requests in, address-tagged
// 32-bit machine words out through a small FIFO.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
  parameter logic [31:0] ADDR_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_instr,
  output logic        err,
  output logic [15:0] words_out
);

  logic [31:0] next_addr_q, next_addr_d;
  logic        err_q, err_d;
  logic [15:0] words_q, words_d;
  logic [31:0] enc_word;
  logic        op_ok, accept, push, pop;
  logic        fifo_full, fifo_empty;
  im_word_t    wr_entry, head;

  always_comb begin
    enc_word = '0;
    case (sym_op_e'(in_op))
      OP_NOP:  enc_word = '0;
      OP_ADD:  enc_word = {OPC_SPECIAL, in_rs, in_rt, in_rd, 5'b0, FUNCT_ADD};
      OP_SUB:  enc_word = {OPC_SPECIAL, in_rs, in_rt, in_rd, 5'b0, FUNCT_SUB};
      OP_ORI:  enc_word = {OPC_ORI, in_rs, in_rt, in_imm};
      OP_LW:   enc_word = {OPC_LW, in_rs, in_rt, in_imm};
      OP_SW:   enc_word = {OPC_SW, in_rs, in_rt, in_imm};
      OP_LUI:  enc_word = {OPC_LUI, 5'b0, in_rt, in_imm};
      OP_BEQ:  enc_word = {OPC_BEQ, in_rs, in_rt, in_imm};
      OP_J:    enc_word = {OPC_J, in_target};
      OP_JAL:  enc_word = {OPC_JAL, in_target};
      OP_JR:   enc_word = {OPC_SPECIAL, in_rs, 15'b0, FUNCT_JR};
      default: enc_word = '0;
    endcase
  end

  assign op_ok     = sym_op_valid(in_op);
  assign out_valid = reset & ~fifo_empty;
  assign in_ready  = reset & ~clear & (~fifo_full | (out_valid & out_ready));
  assign accept    = in_valid & in_ready;
  // Reserved ops complete the handshake but never reach the FIFO.
  assign push      = accept & op_ok;
  assign pop       = out_valid & out_ready & ~clear;

  assign wr_entry  = '{addr: next_addr_q, instr: enc_word};
  assign out_addr  = out_valid ? head.addr  : '0;
  assign out_instr = out_valid ? head.instr : '0;
  assign err       = err_q;
  assign words_out = words_q;

  instr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    next_addr_d = next_addr_q;
    err_d       = err_q;
    words_d     = words_q;
    if (clear) begin
      next_addr_d = BASE_ADDR;
      err_d       = 1'b0;
    end else begin
      if (push)                      next_addr_d = next_addr_q + ADDR_STEP;
      if (accept && !op_ok)          err_d       = 1'b1;
      if (pop && (words_q != '1))    words_d     = words_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      next_addr_q <= BASE_ADDR;
      err_q       <= 1'b0;
      words_q     <= '0;
    end else begin
      next_addr_q <= next_addr_d;
      err_q       <= err_d;
      words_q     <= words_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a reference model predicts each
// emitted word and flow-control state; a monitor compares what the DUT pops.
module tb_instr_encoder;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        in_ready, out_valid, err;
  logic [31:0] out_addr, out_instr;
  logic [15:0] words_out;

  int unsigned errors = 0, checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] exp_next  = BASE;
  logic        exp_err   = 1'b0;
  logic [15:0] exp_words = '0;
  logic        m_ov, m_ir;

  always #5 clk = ~clk;

  instr_encoder #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE), .ADDR_STEP(32'd4)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_instr(out_instr),
    .err(err), .words_out(words_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding from the field-placement rules; bit 32 flags a legal op.
  function automatic logic [32:0] model_enc(input int op, input int rs, input int rt,
                                            input int rd, input int imm, input int tgt);
    int unsigned f_rs, f_rt, f_rd;
    f_rs = 32'(rs) * 32'h20_0000;
    f_rt = 32'(rt) * 32'h1_0000;
    f_rd = 32'(rd) * 32'h800;
    case (op)
      0:       return {1'b1, 32'h0};
      1:       return {1'b1, 32'(f_rs + f_rt + f_rd + 32)};
      2:       return {1'b1, 32'(f_rs + f_rt + f_rd + 34)};
      3:       return {1'b1, 32'(13 * 32'h400_0000 + f_rs + f_rt + imm)};
      4:       return {1'b1, 32'(35 * 32'h400_0000 + f_rs + f_rt + imm)};
      5:       return {1'b1, 32'(43 * 32'h400_0000 + f_rs + f_rt + imm)};
      6:       return {1'b1, 32'(15 * 32'h400_0000 + f_rt + imm)};
      7:       return {1'b1, 32'(4 * 32'h400_0000 + f_rs + f_rt + imm)};
      8:       return {1'b1, 32'(2 * 32'h400_0000 + tgt)};
      9:       return {1'b1, 32'(3 * 32'h400_0000 + tgt)};
      10:      return {1'b1, 32'(f_rs + 8)};
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  // Model: checks the pre-edge state, then applies what the coming edge does.
  initial forever begin
    logic [32:0] enc;
    @(negedge clk);
    m_ov = reset && (exp_q.size() != 0);
    m_ir = reset && !clear && ((exp_q.size() < DEPTH) || (m_ov && out_ready));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("in_ready", 32'(in_ready), 32'(m_ir));
    chk("err", 32'(err), 32'(exp_err));
    chk("words_out", 32'(words_out), 32'(exp_words));
    if (!reset || clear) begin
      exp_q.delete();
      exp_next = BASE;
      exp_err  = 1'b0;
      if (!reset) exp_words = '0;
    end else begin
      if (m_ov && out_ready && exp_words != 16'hFFFF) exp_words++;
      if (in_valid && m_ir) begin
        enc = model_enc(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd),
                        int'(in_imm), int'(in_target));
        if (enc[32]) begin
          exp_q.push_back('{addr: exp_next, instr: enc[31:0]});
          exp_next = exp_next + 32'd4;
        end else begin
          exp_err = 1'b1;
        end
      end
    end
  end

  // Monitor: compares and retires the head whenever the DUT presents a word.
  initial forever begin
    @(negedge clk);
    #1;
    if (!out_valid) begin
      chk("idle_addr", out_addr, 32'h0);
      chk("idle_instr", out_instr, 32'h0);
    end else if (reset && !clear) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%08h@0x%08h expected none", out_instr, out_addr);
      end else begin
        chk("addr", out_addr, exp_q[0].addr);
        chk("instr", out_instr, exp_q[0].instr);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input int op, input int rs, input int rt, input int rd,
                      input int imm, input int tgt);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_op = 4'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_imm = 16'(imm); in_target = 26'(tgt);
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles (op %0d)", op);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2 ms");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    // Single ops and branch/jump encodings.
    send(1, 1, 2, 3, 0, 0);
    send(3, 0, 1, 0, 16'h1234, 0);
    send(4, 2, 3, 0, 16'hFFFC, 0);
    send(7, 1, 2, 0, 3, 0);
    send(9, 0, 0, 0, 0, 26'h0000C03);
    send(10, 31, 21, 10, 16'h5A5A, 26'h3FFFFFF);
    send(6, 7, 4, 0, 16'hABCD, 0);
    send(2, 31, 30, 29, 16'hFFFF, 0);
    send(8, 0, 0, 0, 0, 26'h2AAAAAA);
    drain();

    // Backpressure: fifth request waits until the consumer drains.
    pulse_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1, i, i + 1, i + 2, 0, 0);
    fork
      send(5, 9, 10, 0, 16'h0040, 0);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Full FIFO with a push and a pop on the same edge.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3, i, i, 0, 16'h1000 + i, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(4, i, 31 - i, 0, 16'h2000 + i, 0);
    drain();

    // Reserved op between two legal ones, then clear.
    pulse_clear();
    send(1, 1, 2, 3, 0, 0);
    send(12, 1, 2, 3, 0, 0);
    send(1, 4, 5, 6, 0, 0);
    drain();
    pulse_clear();
    send(1, 7, 8, 9, 0, 0);
    drain();

    // Reset while words are buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(2, i, i, i, 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    send(1, 3, 3, 3, 0, 0);
    drain();

    // Random traffic with occasional reserved ops, clears and resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15))
                                              : 4'($urandom_range(0, 10));
      in_rs     = 5'($urandom);
      in_rt     = 5'($urandom);
      in_rd     = 5'($urandom);
      in_imm    = 16'($urandom);
      in_target = 26'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 99) == 0);
      reset     = ($urandom_range(0, 199) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    clear = 1'b0;
    reset = 1'b1;
    drain();
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
